// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   state_e : controller FSM states
//   RES_*   : result encoding, packed as {gt, eq, lt}
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/cmp2_slice.sv
// Combinational 2-bit magnitude comparator slice, written in gate form.
//   a1,a0 : operand A chunk (a1 = MSB)
//   b1,b0 : operand B chunk
//   gt/eq/lt : one-hot compare result of A1A0 vs B1B0
module cmp2_slice (
    input  logic a1,
    input  logic a0,
    input  logic b1,
    input  logic b0,
    output logic gt,
    output logic eq,
    output logic lt
);
    logic w_x1;
    logic w_x0;

    // XNOR per bit: high when the bit pair matches
    assign w_x1 = ~(a1 ^ b1);
    assign w_x0 = ~(a0 ^ b0);

    assign gt = (a1 & ~b1) | (w_x1 & a0 & ~b0);
    assign lt = (~a1 & b1) | (w_x1 & ~a0 & b0);
    assign eq = w_x1 & w_x0;
endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Serial magnitude comparator: walks two WIDTH-bit operands through one
// shared 2-bit compare slice, MSB chunk first, stopping on the first
// unequal chunk.
//   clk, rst_n      : clock, async active-low reset
//   start, a, b     : request + operands (sampled on accept only)
//   clear           : synchronous abort, wins over start
//   busy            : high while comparing
//   done            : one-cycle pulse when a result is written
//   res_valid       : result fields valid, held until next accept/clear
//   gt, eq, lt      : one-hot result when res_valid
//   steps           : chunks examined for the held result
module serial_mag_compare_ctrl
    import cmp_pkg::*;
#(
    parameter  int WIDTH  = 8,
    localparam int NCHUNK = WIDTH / 2,
    localparam int CW     = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic             res_valid,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CW-1:0]    steps
);
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("serial_mag_compare_ctrl: WIDTH must be even and >= 2");
    end

    state_e           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic             r_valid;
    logic [2:0]       r_res;
    logic [CW-1:0]    r_steps;

    // Chunked views of the operands so the slice mux is a plain index
    logic [NCHUNK-1:0][1:0] w_ca;
    logic [NCHUNK-1:0][1:0] w_cb;
    logic [1:0]             w_a2;
    logic [1:0]             w_b2;
    logic                   w_gt;
    logic                   w_eq;
    logic                   w_lt;

    assign w_ca = r_op_a;
    assign w_cb = r_op_b;
    assign w_a2 = w_ca[r_idx];
    assign w_b2 = w_cb[r_idx];

    cmp2_slice u_slice (
        .a1 (w_a2[1]),
        .a0 (w_a2[0]),
        .b1 (w_b2[1]),
        .b0 (w_b2[0]),
        .gt (w_gt),
        .eq (w_eq),
        .lt (w_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_res   <= RES_NONE;
            r_steps <= '0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_res   <= RES_NONE;
                r_steps <= '0;
            end else begin
                case (r_state)
                    // DONE accepts a new request directly, giving back-to-back operation
                    IDLE, DONE: begin
                        if (start) begin
                            r_op_a  <= a;
                            r_op_b  <= b;
                            r_idx   <= IW'(NCHUNK - 1);
                            r_cnt   <= '0;
                            r_valid <= 1'b0;
                            r_res   <= RES_NONE;
                            r_steps <= '0;
                            r_state <= RUN;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    RUN: begin
                        if (!w_eq) begin
                            r_res   <= w_gt ? RES_GT : RES_LT;
                            r_steps <= r_cnt + 1'b1;
                            r_valid <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else if (r_idx == '0) begin
                            r_res   <= RES_EQ;
                            r_steps <= CW'(NCHUNK);
                            r_valid <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx <= r_idx - 1'b1;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // w_lt is implied by !w_eq && !w_gt; kept for the slice's full interface
    logic w_unused;
    assign w_unused = w_lt;

    assign busy      = (r_state == RUN);
    assign done      = r_done;
    assign res_valid = r_valid;
    assign gt        = r_res[2];
    assign eq        = r_res[1];
    assign lt        = r_res[0];
    assign steps     = r_steps;
endmodule

// File: doc/serial_mag_compare_ctrl.md
Name: serial_mag_compare_ctrl

Overview:
Sequencer that compares two WIDTH-bit unsigned operands by driving a 2-bit magnitude-compare slice (A1A0 vs B1B0 → gt/eq/lt) one chunk per clock, MSB chunk first. It terminates early on the first unequal chunk and reports a registered gt/eq/lt result with a done pulse. Requesters use a start/busy handshake. This reuses the small gate-level comparator as a shared serial resource instead of building a full-width comparator.

Parameters:
WIDTH, 8, operand width in bits; must be even and ≥2. Elaboration fails (generate-time error) otherwise.
NCHUNK, WIDTH/2, derived (localparam): number of 2-bit chunks.
CW, $clog2(NCHUNK+1), derived (localparam): width of the steps counter.

Ports:
clk  input  1  single system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted when start=1 and busy=0 at a rising edge
a  input  WIDTH  operand A, sampled only on accept
b  input  WIDTH  operand B, sampled only on accept
clear  input  1  synchronous abort/clear; priority over start
busy  output  1  1 while in RUN
done  output  1  one-cycle pulse when a result is written
res_valid  output  1  result fields valid; held until next accept/clear/reset
gt  output  1  a > b
eq  output  1  a == b
lt  output  1  a < b
steps  output  CW  number of chunks examined for the held result (1..NCHUNK)

Behaviour:
- Clock/reset fixed: one clock clk; rst_n asynchronous, active-low.
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, res_valid=0, gt=eq=lt=0, steps=0, operand regs=0, idx=0.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, with start=1 and clear=0:
  - Latch a/b into op_a/op_b.
  - Set idx=NCHUNK-1 and cnt=0.
  - Clear res_valid/gt/eq/lt/steps to 0.
  - Go to RUN.
- RUN, each cycle: the slice compares op_a[2*idx+1:2*idx] with op_b[2*idx+1:2*idx] combinationally. Registered at the next edge:
  - chunk gt or lt: write gt/lt accordingly, eq=0, steps=cnt+1, res_valid=1, done=1; go to DONE.
  - chunk eq and idx==0: eq=1, gt=lt=0, steps=NCHUNK, res_valid=1, done=1; go to DONE.
  - chunk eq and idx>0: idx-=1, cnt+=1; stay in RUN.
- Latency: if the accept edge is E0 and the deciding chunk is the n-th examined, done=1 in the cycle following edge En. n=1..NCHUNK; worst case NCHUNK.
- DONE lasts exactly one cycle:
  - start=1 in DONE is accepted (back-to-back), giving done=1 and a new accept in the same cycle.
  - otherwise go to IDLE. done drops; res_valid/gt/eq/lt/steps are held.
- start while busy=1: ignored, not queued. Operands are not resampled.
- clear=1 (any state): next state IDLE; busy/done/res_valid/gt/eq/lt/steps go to 0. start in the same cycle is ignored.
- Reset mid-RUN: immediate return to reset values; no done is generated.
- Invariant: exactly one of gt/eq/lt=1 when res_valid=1; all three are 0 when res_valid=0.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package cmp_pkg:
  - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - result encoding constants: RES_GT, RES_EQ, RES_LT.
- Sub-module cmp2_slice: purely combinational. Inputs a1,a0,b1,b0. Outputs gt,eq,lt. Instantiated once and muxed by idx.
- Controller holds the FSM, idx/cnt counters, operand registers and result registers.

Test Plan:
- WIDTH=8: accept a=8'hA5, b=8'h35 → chunk 10>00, done at E1, gt=1, steps=1, busy high for 1 cycle.
- a=8'h3C, b=8'h3D → 3 equal chunks then 00<01: done at E4, lt=1, steps=4. Repeat with a=b=8'h3C → eq=1, steps=4.
- Accept a=8'h00, b=8'h01. Pulse start with a=8'hFF, b=8'h00 at E2 (busy=1) → ignored; result lt=1, steps=4. Start is accepted in the DONE cycle with a=8'hC0, b=8'h40 → done next at E+1, gt=1, steps=1.
- Mid-RUN (a=b=8'h55, after E2): drive rst_n=0 asynchronously → all outputs 0 immediately. Repeat with clear=1 → IDLE next edge, no done.
- Randomized 1000 pairs, WIDTH=8 and WIDTH=16: result matches a>b/a==b/a<b; steps = 1 + number of leading equal chunks (capped at NCHUNK); one-hot invariant holds.
